// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters.
// The ALU is driven with A (with BEGIN), then B, and then waits for END or a timeout.
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             done0,
  output logic [WIDTH-1:0] res0,
  output logic             err0,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] res1,
  output logic             err1,
  output logic             alu_begin,
  output logic [1:0]       alu_op_code,
  output logic [WIDTH-1:0] alu_inbus,
  input  logic [WIDTH-1:0] alu_outbus,
  input  logic             alu_end,
  output logic             busy
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    owner_q, owner_d;
  logic [1:0]              op_q, op_d;
  logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    timeout;
  logic                    winner;
  logic [1:0]              gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [1:0][WIDTH-1:0]   res_q, res_d;
  logic                    begin_q, begin_d;
  logic [1:0]              opc_q, opc_d;
  logic [WIDTH-1:0]        inbus_q, inbus_d;
  logic                    busy_q, busy_d;

  // A lone request wins outright; the pointer only breaks a tie.
  assign winner = req1 && (!req0 || ptr_q);

  // NOTE: asynchronous reset clears every register, so all outputs drop the moment reset goes low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      res_q   <= '0;
      begin_q <= 1'b0;
      opc_q   <= '0;
      inbus_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
      begin_q <= begin_d;
      opc_q   <= opc_d;
      inbus_q <= inbus_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = '0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = SEND_A;
          owner_d = winner;
          ptr_d   = ~winner;
          op_d    = winner ? op1 : op0;
          a_d     = winner ? a1  : a0;
          b_d     = winner ? b1  : b0;
        end
      end
      SEND_A: state_d = SEND_B;
      SEND_B: state_d = WAIT;
      WAIT: begin
        if (alu_end) begin
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: their next values follow the next state.
  always_comb begin
    gnt_d   = '0;
    done_d  = '0;
    err_d   = err_q;
    res_d   = res_q;
    begin_d = (state_d == SEND_A);
    busy_d  = (state_d != IDLE);
    opc_d   = opc_q;
    inbus_d = inbus_q;
    if (state_q == IDLE && state_d == SEND_A) begin
      gnt_d[owner_d] = 1'b1;
      err_d[owner_d] = 1'b0;
    end
    if (state_d == SEND_A) begin
      opc_d   = op_d;
      inbus_d = a_d;
    end else if (state_d == SEND_B) begin
      inbus_d = b_q;
    end
    if (state_q == WAIT && state_d == RESP) begin
      done_d[owner_q] = 1'b1;
      if (timeout) err_d[owner_q] = 1'b1;
      else         res_d[owner_q] = alu_outbus;
    end
  end

  assign gnt0        = gnt_q[0];
  assign gnt1        = gnt_q[1];
  assign done0       = done_q[0];
  assign done1       = done_q[1];
  assign err0        = err_q[0];
  assign err1        = err_q[1];
  assign res0        = res_q[0];
  assign res1        = res_q[1];
  assign alu_begin   = begin_q;
  assign alu_op_code = opc_q;
  assign alu_inbus   = inbus_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU, a done-side scoreboard, a vector
// table for single-requester traffic and hand sequences for the corner cases.
module tb_alu_arbiter;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 12;

  logic             clk;
  logic             reset;
  logic             req0, req1;
  logic [1:0]       op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, done0, err0, gnt1, done1, err1;
  logic [WIDTH-1:0] res0, res1;
  logic             alu_begin, alu_end, busy;
  logic [1:0]       alu_op_code;
  logic [WIDTH-1:0] alu_inbus, alu_outbus;

  logic             mute, man_end, mdl_end;
  logic [WIDTH-1:0] man_bus, mdl_bus;
  int               alu_lat;

  assign alu_end    = mute ? man_end : mdl_end;
  assign alu_outbus = mute ? man_bus : mdl_bus;

  alu_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .done0(done0), .res0(res0), .err0(err0),
    .gnt1(gnt1), .done1(done1), .res1(res1), .err1(err1),
    .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
    .alu_outbus(alu_outbus), .alu_end(alu_end), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] res;
    logic             err;
  } exp_t;

  typedef struct {
    int               idx;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               lat;
    logic [WIDTH-1:0] res;
  } vec_t;

  exp_t             sb[$];
  int               n_vec = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] last_res[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [WIDTH-1:0] r, input logic er);
    exp_t e;
    e.idx = idx;
    e.res = r;
    e.err = er;
    sb.push_back(e);
    if (!er) last_res[idx] = r;
  endtask

  function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Behavioural ALU: takes A with BEGIN, B the next cycle, answers alu_lat cycles into WAIT.
  initial begin
    logic [1:0]       m_op;
    logic [WIDTH-1:0] m_a, m_b;
    mdl_end = 1'b0;
    mdl_bus = '0;
    forever begin
      @(negedge clk);
      if (alu_begin) begin
        m_op = alu_op_code;
        m_a  = alu_inbus;
        @(negedge clk);
        m_b = alu_inbus;
        repeat (alu_lat) @(negedge clk);
        @(negedge clk);
        mdl_bus = alu_fn(m_op, m_a, m_b);
        mdl_end = 1'b1;
        @(negedge clk);
        mdl_end = 1'b0;
      end
    end
  end

  // Scoreboard side: every done pulse pops and compares one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0 || done1) begin
        check("done_exclusive", {31'd0, done0 & done1}, 32'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: done0=%0b done1=%0b, required no done", done0, done1);
        end else begin
          e = sb.pop_front();
          check("done_owner", {31'd0, done1}, e.idx);
          check("result", done1 ? res1 : res0, e.res);
          check("err_flag", done1 ? err1 : err0, e.err);
        end
      end
    end
  end

  task automatic set_req(input int idx, input logic v, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (idx == 0) begin req0 = v; op0 = op; a0 = a; b0 = b; end
    else          begin req1 = v; op1 = op; a1 = a; b1 = b; end
  endtask

  task automatic wait_gnt(input int budget, output int who);
    who = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        who = gnt1 ? 1 : 0;
        break;
      end
    end
    if (who < 0) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done0 || done1) break;
    end
    if (!(done0 || done1)) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {22'd0, busy, gnt0, gnt1, done0, done1, err0, err1, alu_begin, alu_op_code}, 32'd0);
    check({name, "_data"}, {8'd0, res0, res1, alu_inbus}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_values");
    @(negedge clk);
    reset = 1'b1;
    last_res[0] = '0;
    last_res[1] = '0;
  endtask

  task automatic run_single(input vec_t v);
    int who, cyc;
    alu_lat = v.lat;
    @(negedge clk);
    set_req(v.idx, 1'b1, v.op, v.a, v.b);
    push_exp(v.idx, v.res, 1'b0);
    wait_gnt(8, who);
    check("gnt_owner", who, v.idx);
    check("err_cleared_on_gnt", (v.idx == 1) ? err1 : err0, 32'd0);
    check("send_a_begin", {31'd0, alu_begin}, 32'd1);
    check("send_a_bus", alu_inbus, v.a);
    check("send_a_op", alu_op_code, v.op);
    set_req(v.idx, 1'b0, v.op, v.a, v.b);
    @(negedge clk);
    check("send_b_begin", {31'd0, alu_begin}, 32'd0);
    check("send_b_bus", alu_inbus, v.b);
    check("send_b_busy", {31'd0, busy}, 32'd1);
    wait_done(40, cyc);
    check("done_latency", cyc, 2 + v.lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int   who, cyc;

    vt[0] = '{idx: 0, op: 2'b00, a: 8'd3,   b: 8'd2,   lat: 0, res: 8'd5};
    vt[1] = '{idx: 1, op: 2'b00, a: 8'hF0,  b: 8'h20,  lat: 2, res: 8'h10};
    vt[2] = '{idx: 0, op: 2'b01, a: 8'd10,  b: 8'd3,   lat: 1, res: 8'd7};
    vt[3] = '{idx: 1, op: 2'b10, a: 8'hCC,  b: 8'hAA,  lat: 0, res: 8'h88};
    vt[4] = '{idx: 0, op: 2'b11, a: 8'h5A,  b: 8'hFF,  lat: 3, res: 8'hA5};
    vt[5] = '{idx: 1, op: 2'b00, a: 8'hFF,  b: 8'h01,  lat: 0, res: 8'h00};

    reset = 1'b0;
    mute = 1'b0; man_end = 1'b0; man_bus = '0; alu_lat = 0;
    req0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
    req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    last_res[0] = '0;
    last_res[1] = '0;
    #12;
    check_reset_outputs("reset_values");
    @(negedge clk);
    reset = 1'b1;

    foreach (vt[i]) run_single(vt[i]);

    // Simultaneous requests held high: grants alternate starting from requester 0.
    do_reset();
    alu_lat = 0;
    @(negedge clk);
    set_req(0, 1'b1, 2'b00, 8'd7, 8'd3);
    set_req(1, 1'b1, 2'b00, 8'd4, 8'd4);
    push_exp(0, 8'd10, 1'b0);
    push_exp(1, 8'd8,  1'b0);
    push_exp(0, 8'd10, 1'b0);
    push_exp(1, 8'd8,  1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(12, who);
      check("rr_grant", who, k % 2);
    end
    set_req(0, 1'b0, 2'b00, 8'd7, 8'd3);
    set_req(1, 1'b0, 2'b00, 8'd4, 8'd4);
    wait_done(20, cyc);

    // Pointer is back at 0; requester 1 stays pending through the whole operation.
    @(negedge clk);
    set_req(0, 1'b1, 2'b01, 8'h11, 8'h22);
    set_req(1, 1'b1, 2'b10, 8'h0F, 8'h3C);
    push_exp(0, 8'hEF, 1'b0);
    push_exp(1, 8'h0C, 1'b0);
    wait_gnt(8, who);
    check("ptr_after_pairs", who, 0);
    set_req(0, 1'b0, 2'b01, 8'h11, 8'h22);
    wait_gnt(12, who);
    check("pending_req1", who, 1);
    set_req(1, 1'b0, 2'b10, 8'h0F, 8'h3C);
    wait_done(20, cyc);

    // Timeout: ALU never answers.
    mute = 1'b1;
    man_end = 1'b0;
    @(negedge clk);
    set_req(1, 1'b1, 2'b00, 8'd1, 8'd1);
    push_exp(1, last_res[1], 1'b1);
    wait_gnt(8, who);
    check("timeout_gnt", who, 1);
    set_req(1, 1'b0, 2'b00, 8'd1, 8'd1);
    wait_done(TIMEOUT + 20, cyc);
    check("timeout_latency", cyc, 2 + TIMEOUT);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, err1}, 32'd1);
    check("res_kept_on_timeout", res1, last_res[1]);
    mute = 1'b0;
    run_single('{idx: 1, op: 2'b00, a: 8'd1, b: 8'd1, lat: 0, res: 8'd2});

    // Reset while waiting on the ALU: no done, then normal operation.
    mute = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 2'b00, 8'h40, 8'h01);
    wait_gnt(8, who);
    check("abort_gnt", who, 0);
    set_req(0, 1'b0, 2'b00, 8'h40, 8'h01);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_in_wait");
    @(negedge clk);
    reset = 1'b1;
    last_res[0] = '0;
    last_res[1] = '0;
    mute = 1'b0;
    run_single('{idx: 0, op: 2'b00, a: 8'h21, b: 8'h12, lat: 0, res: 8'h33});

    // END pulsed during SEND_A/SEND_B must not complete the operation.
    mute = 1'b1;
    man_end = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 2'b00, 8'd9, 8'd4);
    push_exp(0, 8'd13, 1'b0);
    wait_gnt(8, who);
    check("early_end_gnt", who, 0);
    set_req(0, 1'b0, 2'b00, 8'd9, 8'd4);
    man_end = 1'b1;
    man_bus = 8'h77;
    @(negedge clk);
    man_bus = 8'h66;
    @(negedge clk);
    man_end = 1'b0;
    check("early_end_ignored", {30'd0, done0, busy}, 32'd1);
    @(negedge clk);
    man_bus = 8'd13;
    man_end = 1'b1;
    @(negedge clk);
    man_end = 1'b0;
    check("late_end_done", {31'd0, done0}, 32'd1);
    mute = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width, matching the ALU inbus/outbus.
REQ-002 Parameter TIMEOUT, default 200: max cycles waited for alu_end before abort.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 reqN  in  1  (N=0,1) requester N operation request, level, held until gntN.
REQ-006 opN  in  2  requester N op_code (00 add, others passed through unchanged).
REQ-007 aN, bN  in  WIDTH  requester N operands A and B, stable while reqN high.
REQ-008 gntN  out  1  one-cycle pulse: request N accepted, operands latched.
REQ-009 doneN  out  1  one-cycle pulse: resN valid (or errN set).
REQ-010 resN  out  WIDTH  last result for requester N, held until its next done.
REQ-011 errN  out  1  sticky timeout flag for requester N, cleared on its next gntN.
REQ-012 alu_begin  out  1  BEGIN to ALU.
REQ-013 alu_op_code  out  2  op_code to ALU.
REQ-014 alu_inbus  out  WIDTH  operand bus to ALU.
REQ-015 alu_outbus  in  WIDTH  ALU result.
REQ-016 alu_end  in  1  ALU END, result valid while high.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, SEND_A, SEND_B, WAIT, RESP; all outputs registered.
REQ-019 IDLE: edge with any req high -> SEND_A; winner's op/a/b latched, winner's gnt high for the SEND_A cycle.
REQ-020 Arbitration SHALL be round-robin: 1-bit pointer, reset 0; if both req high, pointer index wins; after every grant pointer = other index; single req always wins regardless of pointer.
REQ-021 SEND_A (1 cycle): alu_begin=1, alu_op_code=latched op, alu_inbus=latched A; -> SEND_B.
REQ-022 SEND_B (1 cycle): alu_begin=0, alu_inbus=latched B; -> WAIT.
REQ-023 WAIT: alu_inbus holds B, alu_op_code holds op; edge with alu_end=1 -> capture alu_outbus into owner's res, -> RESP.
REQ-024 WAIT timeout: 8-bit+ counter cleared on entering WAIT; when it reaches TIMEOUT with no alu_end -> set owner's err, res unchanged, -> RESP.
REQ-025 RESP (1 cycle): owner's done=1; -> IDLE; a req is sampled again only in IDLE (min 5 cycles grant-to-grant).
REQ-026 alu_end outside WAIT SHALL be ignored; reqs in non-IDLE states SHALL be held pending, never dropped.
REQ-027 Result width: res = alu_outbus[WIDTH-1:0], no extension or check of overflow.
REQ-028 Latency req-to-done with alu_end on first WAIT cycle: 4 edges (SEND_A, SEND_B, WAIT, RESP).

Reset
REQ-029 reset low SHALL immediately force IDLE, pointer=0, counter=0, alu_begin=0, alu_op_code=0, alu_inbus=0, gnt/done/err=0, res=0, busy=0.
REQ-030 Reset mid-operation SHALL abort with no done pulse; first edge after release behaves as IDLE.

Verification
REQ-031 req0, op0=00, a0=3, b0=2; ALU returns 5 -> SEND_A inbus=3 begin=1, SEND_B inbus=2 begin=0, res0=5, done0 one cycle, err0=0.
REQ-032 After reset, req0 and req1 same edge (a0=7,b0=3; a1=4,b1=4, add) -> gnt0 first, res0=10, then gnt1, res1=8; pointer ends 0.
REQ-033 Both reqs continuously high for 4 ops -> grants alternate 0,1,0,1.
REQ-034 req1 a1=1,b1=1, alu_end held low -> done1 exactly TIMEOUT cycles after WAIT entry, err1=1, res1 unchanged; next gnt1 clears err1.
REQ-035 reset low during WAIT -> all outputs at reset values same cycle, no doneN; new req0 after release completes normally.
REQ-036 alu_end pulsed during SEND_A/SEND_B -> ignored; result captured only on alu_end in WAIT.
